// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port memory bus between the instruction-fetch (IF) port
//   and the data (MEM) port of a 5-stage pipeline. In each pipeline cycle the
//   data access is performed first and the fetch second. Both results are
//   buffered, and the whole pipeline is stalled until the buffers are valid.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   inst_ren, inst_addr, inst_data  IF request (level), address, buffered result
//   mem_ren, mem_wen, mem_addr,
//   mem_dout, mem_din               MEM request (write wins if both), address,
//                                   write data, buffered read result
//   pipe_stall                      freezes all pipeline stage enables
//   bus_req, bus_we, bus_addr,
//   bus_wdata                       registered bus request fields
//   bus_rdata, bus_ack              bus response; bus_ack completes a transaction
//   bus_err                         sticky timeout flag (cleared only by reset)
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_ren,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              pipe_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_WAIT = 2'd1,
    I_WAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [DATA_W-1:0]  inst_buf, data_buf;
  logic               wait_st;
  logic               timed_out;
  logic               tx_done;
  logic               data_req;

  assign data_req  = mem_ren | mem_wen;
  assign wait_st   = (state_q == D_WAIT) || (state_q == I_WAIT);
  // The abort fires in the wait cycle that would bring the count of
  // un-acknowledged cycles up to TIMEOUT.
  assign timed_out = wait_st && !bus_ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign tx_done   = wait_st && (bus_ack || timed_out);

  assign inst_data = inst_buf;
  assign mem_din   = data_buf;

  always_comb begin
    state_d    = state_q;
    pipe_stall = 1'b0;
    case (state_q)
      IDLE: begin
        pipe_stall = data_req | inst_ren;
        if (data_req)      state_d = D_WAIT;
        else if (inst_ren) state_d = I_WAIT;
      end
      D_WAIT: begin
        pipe_stall = 1'b1;
        if (tx_done) state_d = inst_ren ? I_WAIT : DONE;
      end
      I_WAIT: begin
        pipe_stall = 1'b1;
        if (tx_done) state_d = DONE;
      end
      DONE: begin
        pipe_stall = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmo_cnt   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      inst_buf  <= '0;
      data_buf  <= '0;
      bus_err   <= 1'b0;
    end else begin
      state_q <= state_d;

      // Counter restarts on every state change, so each wait state begins at 0.
      if (state_d != state_q) tmo_cnt <= '0;
      else if (wait_st)       tmo_cnt <= tmo_cnt + 1'b1;

      if (timed_out) bus_err <= 1'b1;

      case (state_q)
        IDLE: begin
          // bus_addr/bus_we/bus_wdata double as the latched request fields.
          if (data_req) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_wen;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_dout;
          end else if (inst_ren) begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= inst_addr;
          end
        end
        D_WAIT: begin
          if (tx_done) begin
            if (!bus_we) data_buf <= timed_out ? '0 : bus_rdata;
            bus_we <= 1'b0;
            if (inst_ren) begin
              // bus_req stays high; the fetch address appears next cycle.
              bus_addr <= inst_addr;
            end else begin
              bus_req <= 1'b0;
            end
          end
        end
        I_WAIT: begin
          if (tx_done) begin
            // A timed-out fetch yields all-zero, which decodes as a NOP.
            inst_buf <= timed_out ? '0 : bus_rdata;
            bus_req  <= 1'b0;
          end
        end
        default: begin
          bus_req <= 1'b0;
          bus_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 6;

  logic              clk;
  logic              rst_n;
  logic              inst_ren;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_data;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem_din;
  logic              pipe_stall;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              bus_err;

  int checks = 0;
  int errors = 0;

  unified_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst_ren  (inst_ren),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .pipe_stall(pipe_stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    inst_ren  = 1'b0;
    inst_addr = '0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_dout  = '0;
    bus_rdata = '0;
    bus_ack   = 1'b0;

    // Reset state
    #2;
    check("rst_bus_req",   bus_req,   0);
    check("rst_bus_we",    bus_we,    0);
    check("rst_bus_addr",  bus_addr,  0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_mem_din",   mem_din,   0);
    check("rst_bus_err",   bus_err,   0);
    check("rst_stall",     pipe_stall, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1. Fetch only
    inst_ren  = 1'b1;
    inst_addr = 32'h100;
    #1 check("t1_idle_stall", pipe_stall, 1);
    step();
    check("t1_req",   bus_req,    1);
    check("t1_addr",  bus_addr,   32'h100);
    check("t1_we",    bus_we,     0);
    check("t1_stall", pipe_stall, 1);
    bus_ack = 1'b1; bus_rdata = 32'h2008_0005;
    step();
    bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    check("t1_done_stall", pipe_stall, 0);
    check("t1_inst_data",  inst_data,  32'h2008_0005);
    check("t1_done_req",   bus_req,    0);
    inst_ren = 1'b0;
    step();
    check("t1_idle_after", pipe_stall, 0);

    // 2. Load + fetch
    mem_ren = 1'b1; mem_addr = 32'h40;
    inst_ren = 1'b1; inst_addr = 32'h104;
    #1 check("t2_idle_stall", pipe_stall, 1);
    step();
    check("t2_d_addr",  bus_addr,   32'h40);
    check("t2_d_we",    bus_we,     0);
    check("t2_d_req",   bus_req,    1);
    check("t2_d_stall", pipe_stall, 1);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_ack = 1'b0;
    check("t2_i_addr",  bus_addr,   32'h104);
    check("t2_i_req",   bus_req,    1);
    check("t2_i_stall", pipe_stall, 1);
    check("t2_mem_din", mem_din,    32'hDEAD_BEEF);
    bus_ack = 1'b1; bus_rdata = 32'h8C09_0000;
    step();
    bus_ack = 1'b0;
    check("t2_done_stall", pipe_stall, 0);
    check("t2_inst_data",  inst_data,  32'h8C09_0000);
    check("t2_done_din",   mem_din,    32'hDEAD_BEEF);
    mem_ren = 1'b0; inst_ren = 1'b0;
    step();

    // 3. Store + fetch
    mem_wen = 1'b1; mem_addr = 32'h44; mem_dout = 32'h1234_5678;
    inst_ren = 1'b1; inst_addr = 32'h108;
    step();
    check("t3_d_we",    bus_we,    1);
    check("t3_d_addr",  bus_addr,  32'h44);
    check("t3_d_wdata", bus_wdata, 32'h1234_5678);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_ack = 1'b0;
    check("t3_din_kept", mem_din,  32'hDEAD_BEEF);
    check("t3_i_we",     bus_we,   0);
    check("t3_i_addr",   bus_addr, 32'h108);
    bus_ack = 1'b1; bus_rdata = 32'h1111_0000;
    step();
    bus_ack = 1'b0;
    check("t3_inst_data", inst_data,  32'h1111_0000);
    check("t3_done_din",  mem_din,    32'hDEAD_BEEF);
    check("t3_done_stall", pipe_stall, 0);
    mem_wen = 1'b0; inst_ren = 1'b0;
    step();

    // 4. Wait states: five cycles without ack, ack in the sixth
    inst_ren = 1'b1; inst_addr = 32'h10C;
    step();
    inst_addr = 32'hFFF0;
    for (int i = 0; i < 5; i++) begin
      check("t4_req",   bus_req,    1);
      check("t4_addr",  bus_addr,   32'h10C);
      check("t4_stall", pipe_stall, 1);
      step();
    end
    check("t4_last_req", bus_req, 1);
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_0001;
    step();
    bus_ack = 1'b0;
    check("t4_inst_data", inst_data,  32'hCAFE_0001);
    check("t4_stall_free", pipe_stall, 0);
    check("t4_bus_err",   bus_err,    0);
    inst_ren = 1'b0;
    step();

    // 5. Timeout on fetch: TIMEOUT wait cycles without ack
    inst_ren = 1'b1; inst_addr = 32'h110;
    step();
    for (int i = 0; i < TIMEOUT; i++) begin
      check("t5_stall", pipe_stall, 1);
      check("t5_err_low", bus_err, 0);
      step();
    end
    check("t5_done_stall", pipe_stall, 0);
    check("t5_inst_nop",   inst_data,  32'h0);
    check("t5_bus_err",    bus_err,    1);
    check("t5_req_low",    bus_req,    0);
    inst_ren = 1'b0;
    step();
    inst_ren = 1'b1; inst_addr = 32'h114;
    step();
    check("t5_next_addr", bus_addr, 32'h114);
    bus_ack = 1'b1; bus_rdata = 32'h0042_0042;
    step();
    bus_ack = 1'b0;
    check("t5_next_data", inst_data, 32'h0042_0042);
    check("t5_err_sticky", bus_err,  1);
    inst_ren = 1'b0;
    step();

    // 6. Reset in D_WAIT
    mem_ren = 1'b1; mem_addr = 32'h48;
    inst_ren = 1'b1; inst_addr = 32'h118;
    step();
    check("t6_d_req", bus_req, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req",   bus_req,    0);
    check("t6_rst_addr",  bus_addr,   0);
    check("t6_rst_inst",  inst_data,  0);
    check("t6_rst_din",   mem_din,    0);
    check("t6_rst_err",   bus_err,    0);
    check("t6_rst_stall", pipe_stall, 1);
    mem_ren = 1'b0;
    #1 rst_n = 1'b1;
    step();
    check("t6_fetch_req",  bus_req,  1);
    check("t6_fetch_addr", bus_addr, 32'h118);
    check("t6_fetch_we",   bus_we,   0);
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    step();
    bus_ack = 1'b0;
    check("t6_inst_data", inst_data,  32'h0BAD_F00D);
    check("t6_stall",     pipe_stall, 0);
    inst_ren = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
